mem_req_arbiter: RTL
====================

Name: mem_req_arbiter

Overview:
- Shares the single accelerator memory port (req addr/cmd/typ/data, resp vld/data/store_data) between NREQ requesters, e.g. several load/store accelerator controllers.
- Allows one outstanding memory transaction at a time.
- Locks the grant from request acceptance until the memory response returns, then routes the response back to the owning requester.
- Sits between the requester control FSMs and the memory interface of the accelerator top level.

Parameters:
- NREQ, 2, number of requesters (2..8).
- OWNER_W, 3, width of the owner index output; must satisfy 2^OWNER_W >= NREQ.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_vld  in  NREQ  per-requester request valid
- req_rdy  out  NREQ  per-requester accept strobe; one-hot or zero
- req_addr  in  40*NREQ  flattened addresses; requester i occupies bits [40i+39:40i]
- req_cmd  in  5*NREQ  flattened memory cmd (0 = load, 1 = store)
- req_typ  in  3*NREQ  flattened access type
- req_data  in  64*NREQ  flattened store data
- resp_vld  out  NREQ  per-requester response valid, one-cycle pulse
- resp_data  out  64  response data, shared by all requesters; qualified by resp_vld
- mem_req_vld  out  1  memory request valid
- mem_req_rdy  in  1  memory request ready
- mem_req_addr  out  40  registered address
- mem_req_cmd  out  5  registered cmd
- mem_req_typ  out  3  registered typ
- mem_req_data  out  64  registered data
- mem_resp_vld  in  1  memory response valid
- mem_resp_data  in  64  load data
- mem_resp_store_data  in  64  store echo data
- busy  out  1  high when state is not IDLE
- owner  out  OWNER_W  index of the current grant holder
- err_spurious  out  1  sticky flag for an unexpected response

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_vld bit is set, the arbiter picks a winner w.
  - req_rdy[w] = 1 combinationally in that same cycle; the handshake is req_vld[w] & req_rdy[w].
  - Registers addr/cmd/typ/data of w and sets owner <= w.
  - Next state is ISSUE.
- ISSUE:
  - mem_req_vld = 1 with the registered fields held stable.
  - On mem_req_rdy, next state is WAIT.
  - Stays in ISSUE indefinitely until mem_req_rdy.
  - mem_req_vld stays high until the handshake; it is never dropped.
- WAIT:
  - On mem_resp_vld, registers resp_data. The source is mem_resp_store_data if the latched cmd == 1, otherwise mem_resp_data.
  - Next state is RESP.
- RESP:
  - resp_vld[owner] = 1 for exactly one cycle; all other resp_vld bits are 0.
  - Next state is IDLE.
  - A new grant is possible in the following cycle.
- Minimum latency:
  - req accept at cycle 0 → mem_req_vld at cycle 1.
  - mem_resp_vld at cycle k → resp_vld at cycle k+1.
  - Round trip is 4 cycles when memory responds immediately.
- Fairness (default, fixed priority): the lowest-index asserted req_vld wins.
- req_rdy is 0 for every requester in ISSUE, WAIT and RESP.
- A requester must hold req_vld and its fields until it is granted.
- mem_resp_vld in IDLE or ISSUE:
  - The response is ignored and no resp_vld is produced.
  - err_spurious is set to 1 and stays set until rst.
- mem_resp_vld in RESP: same handling as above (ignored, err_spurious set).
- mem_req_rdy outside ISSUE: ignored.
- Reset values:
  - state IDLE.
  - req_rdy, resp_vld, mem_req_vld, busy, err_spurious all 0.
  - owner 0; resp_data 0.
  - mem_req_addr/cmd/typ/data 0.
- Reset mid-operation: the outstanding transaction is abandoned, no resp_vld is issued, and a late mem_resp_vld after reset sets err_spurious.

Optional Feature:
- Macro: MEM_REQ_ARBITER_ROUND_ROBIN_EN.
- When defined:
  - A round-robin pointer rr (reset 0) is kept.
  - The IDLE winner is the first asserted req_vld searching from rr upward, wrapping modulo NREQ.
  - On each grant, rr <= (w+1) mod NREQ.
- When undefined: fixed priority, lowest index wins, no pointer register.

Test Plan:
- Single load: NREQ=2, req_vld=01, addr0=0x10_0000_0040, cmd0=0. The bench returns mem_resp_vld with mem_resp_data=0xDEADBEEF_00000001 on the cycle after the handshake. Required: mem_req_vld at cycle 1 with addr 0x1000000040, cmd 0; resp_vld=01 with resp_data=0xDEADBEEF00000001 one cycle after mem_resp_vld.
- Store routing: req_vld=10, cmd1=1, data1=0x55, memory echoes mem_resp_store_data=0x55, mem_resp_data=0xFF. Required: mem_req_cmd=1, mem_req_data=0x55; resp_vld=10, resp_data=0x55.
- Contention and backpressure: req_vld=11 held continuously, mem_req_rdy low for 3 cycles. Required: requester 0 is granted first; mem_req_vld is held for 3 cycles with stable fields; requester 1 is granted only after resp_vld=01. With the macro defined, the third grant goes back to requester 0 and alternation continues; without it, requester 0 wins every time both request.
- Spurious response: mem_resp_vld pulsed in IDLE. Required: no resp_vld and err_spurious=1; err_spurious clears only on rst.
- Reset mid-operation: rst asserted in WAIT, then mem_resp_vld arrives 2 cycles after reset release. Required: busy=0 and no resp_vld; err_spurious=1; a subsequent request completes normally.

Source files
------------

// File: rtl/mem_req_arbiter_if.sv
// Requester-side and memory-side signals of mem_req_arbiter.
// slave = arbiter view, master = requesters plus memory (the environment).
interface mem_req_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_vld;
  logic [NREQ-1:0]    req_rdy;
  logic [40*NREQ-1:0] req_addr;
  logic [5*NREQ-1:0]  req_cmd;
  logic [3*NREQ-1:0]  req_typ;
  logic [64*NREQ-1:0] req_data;
  logic [NREQ-1:0]    resp_vld;
  logic [63:0]        resp_data;

  logic               mem_req_vld;
  logic               mem_req_rdy;
  logic [39:0]        mem_req_addr;
  logic [4:0]         mem_req_cmd;
  logic [2:0]         mem_req_typ;
  logic [63:0]        mem_req_data;
  logic               mem_resp_vld;
  logic [63:0]        mem_resp_data;
  logic [63:0]        mem_resp_store_data;

  modport slave (
    input  req_vld, req_addr, req_cmd, req_typ, req_data,
    input  mem_req_rdy, mem_resp_vld, mem_resp_data, mem_resp_store_data,
    output req_rdy, resp_vld, resp_data,
    output mem_req_vld, mem_req_addr, mem_req_cmd, mem_req_typ, mem_req_data
  );

  modport master (
    output req_vld, req_addr, req_cmd, req_typ, req_data,
    output mem_req_rdy, mem_resp_vld, mem_resp_data, mem_resp_store_data,
    input  req_rdy, resp_vld, resp_data,
    input  mem_req_vld, mem_req_addr, mem_req_cmd, mem_req_typ, mem_req_data
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one memory port between NREQ requesters, one transaction in flight at a time.
// Define MEM_REQ_ARBITER_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).
module mem_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int OWNER_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  mem_req_arbiter_if.slave   bus,
  output logic               busy_o,
  output logic [OWNER_W-1:0] owner_o,
  output logic               err_spurious_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [4:0] CMD_STORE = 5'd1;

  state_e             state_q;
  logic [OWNER_W-1:0] owner_q;
  logic [39:0]        addr_q;
  logic [4:0]         cmd_q;
  logic [2:0]         typ_q;
  logic [63:0]        data_q;
  logic               mem_req_vld_q;
  logic [NREQ-1:0]    resp_vld_q;
  logic [63:0]        resp_data_q;
  logic               err_spurious_q;

  logic               any_vld;
  logic [OWNER_W-1:0] win_idx;
  logic [39:0]        sel_addr;
  logic [4:0]         sel_cmd;
  logic [2:0]         sel_typ;
  logic [63:0]        sel_data;

`ifdef MEM_REQ_ARBITER_ROUND_ROBIN_EN
  logic [OWNER_W-1:0] rr_q;
  logic [OWNER_W-1:0] rr_d;
  logic [NREQ-1:0]    rot_vld;
  logic [OWNER_W:0]   rr_sum;
`endif

  // Winner selection and field mux for the requester that would be granted this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    any_vld  = 1'b0;
    win_idx  = '0;
    sel_addr = '0;
    sel_cmd  = '0;
    sel_typ  = '0;
    sel_data = '0;
`ifdef MEM_REQ_ARBITER_ROUND_ROBIN_EN
    // Rotate so bit 0 is requester rr_q, pick the lowest set bit, then undo the rotation.
    rot_vld = NREQ'({bus.req_vld, bus.req_vld} >> rr_q);
    rr_sum  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_vld[k]) begin
        any_vld = 1'b1;
        rr_sum  = {1'b0, rr_q} + (OWNER_W + 1)'(k);
      end
    end
    if (rr_sum >= (OWNER_W + 1)'(NREQ)) begin
      rr_sum = rr_sum - (OWNER_W + 1)'(NREQ);
    end
    win_idx = rr_sum[OWNER_W-1:0];
    rr_d    = (win_idx == OWNER_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`else
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_vld[k]) begin
        any_vld = 1'b1;
        win_idx = OWNER_W'(k);
      end
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == OWNER_W'(k)) begin
        sel_addr = bus.req_addr[k*40 +: 40];
        sel_cmd  = bus.req_cmd[k*5 +: 5];
        sel_typ  = bus.req_typ[k*3 +: 3];
        sel_data = bus.req_data[k*64 +: 64];
      end
    end
  end

  // Accept strobe is gated by rst so a requester never sees a grant that reset discards.
  assign bus.req_rdy = (!rst && state_q == IDLE && any_vld) ? (NREQ'(1) << win_idx) : '0;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= '0;
      addr_q         <= '0;
      cmd_q          <= '0;
      typ_q          <= '0;
      data_q         <= '0;
      mem_req_vld_q  <= 1'b0;
      resp_vld_q     <= '0;
      resp_data_q    <= '0;
      err_spurious_q <= 1'b0;
`ifdef MEM_REQ_ARBITER_ROUND_ROBIN_EN
      rr_q           <= '0;
`endif
    end else begin
      resp_vld_q <= '0;
      // Only WAIT expects a memory response; anything else is flagged and dropped.
      if (bus.mem_resp_vld && state_q != WAIT) begin
        err_spurious_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (any_vld) begin
            owner_q       <= win_idx;
            addr_q        <= sel_addr;
            cmd_q         <= sel_cmd;
            typ_q         <= sel_typ;
            data_q        <= sel_data;
            mem_req_vld_q <= 1'b1;
            state_q       <= ISSUE;
`ifdef MEM_REQ_ARBITER_ROUND_ROBIN_EN
            rr_q          <= rr_d;
`endif
          end
        end
        ISSUE: begin
          if (bus.mem_req_rdy) begin
            mem_req_vld_q <= 1'b0;
            state_q       <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_resp_vld) begin
            resp_data_q <= (cmd_q == CMD_STORE) ? bus.mem_resp_store_data : bus.mem_resp_data;
            resp_vld_q  <= NREQ'(1) << owner_q;
            state_q     <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req_vld  = mem_req_vld_q;
  assign bus.mem_req_addr = addr_q;
  assign bus.mem_req_cmd  = cmd_q;
  assign bus.mem_req_typ  = typ_q;
  assign bus.mem_req_data = data_q;
  assign bus.resp_vld     = resp_vld_q;
  assign bus.resp_data    = resp_data_q;
  assign busy_o           = (state_q != IDLE);
  assign owner_o          = owner_q;
  assign err_spurious_o   = err_spurious_q;

endmodule
